// File: rtl/car_pkg.sv
// Shared constants for the car counting / scoring / light control path.
package car_pkg;

    localparam int CAR_W    = 6;
    localparam int MAX_CARS = 50;

    localparam int DIR_N = 3;
    localparam int DIR_S = 2;
    localparam int DIR_E = 1;
    localparam int DIR_W = 0;

endpackage

// File: rtl/dir_counter.sv
// One direction: arrive synchronizer, rising-edge detector, saturating queue count and
// sticky overflow/underflow flags.
module dir_counter
    import car_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MAX_CARS
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             arrive,
    input  logic             depart,
    output logic [CAR_W-1:0] count,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [CAR_W-1:0] MAX_C = CAR_W'(MAX_COUNT);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_hist;
    logic [CAR_W-1:0] r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             w_arr;

    // The synchronizer keeps running through clear; only the counting state is cleared.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= arrive;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_arr = r_sync2 & ~r_hist;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            case ({w_arr, depart})
                2'b10: begin
                    if (r_count < MAX_C) r_count <= r_count + 1'b1;
                    else                 r_ovf   <= 1'b1;
                end
                2'b01: begin
                    if (r_count != '0) r_count <= r_count - 1'b1;
                    else               r_udf   <= 1'b1;
                end
                default: ;  // none, or arrival and departure cancel out
            endcase
        end
    end

    assign count = r_count;
    assign full  = (r_count == MAX_C);
    assign ovf   = r_ovf;
    assign udf   = r_udf;

endmodule

// File: rtl/car_counter.sv
// Four independent per-direction occupancy counters feeding the car-score stage.
module car_counter
    import car_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MAX_CARS
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic [3:0]       arrive,
    input  logic [3:0]       depart,
    output logic [CAR_W-1:0] n_count,
    output logic [CAR_W-1:0] s_count,
    output logic [CAR_W-1:0] e_count,
    output logic [CAR_W-1:0] w_count,
    output logic [3:0]       full,
    output logic [3:0]       ovf,
    output logic [3:0]       udf
);

    logic [3:0][CAR_W-1:0] w_cnt;

    for (genvar g = 0; g < 4; g++) begin : g_dir
        dir_counter #(
            .MAX_COUNT(MAX_COUNT)
        ) u_dir (
            .clk   (clk),
            .n_rst (n_rst),
            .clear (clear),
            .arrive(arrive[g]),
            .depart(depart[g]),
            .count (w_cnt[g]),
            .full  (full[g]),
            .ovf   (ovf[g]),
            .udf   (udf[g])
        );
    end

    assign n_count = w_cnt[DIR_N];
    assign s_count = w_cnt[DIR_S];
    assign e_count = w_cnt[DIR_E];
    assign w_count = w_cnt[DIR_W];

endmodule

// File: tb/tb_car_counter.sv
// Directed self-checking bench for car_counter.
module tb_car_counter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic [3:0] arrive;
    logic [3:0] depart;
    logic [5:0] n_count, s_count, e_count, w_count;
    logic [3:0] full, ovf, udf;

    int total = 0;
    int bad   = 0;

    car_counter #(
        .MAX_COUNT(50)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (clear),
        .arrive (arrive),
        .depart (depart),
        .n_count(n_count),
        .s_count(s_count),
        .e_count(e_count),
        .w_count(w_count),
        .full   (full),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 2 cycles high, 2 low: each masked direction counts exactly once.
    task automatic pulse(input logic [3:0] mask);
        arrive = mask;
        tick(2);
        arrive = 4'b0000;
        tick(2);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        n_rst  = 1'b0;
        clear  = 1'b0;
        arrive = 4'b0000;
        depart = 4'b0000;
        tick(3);
        check("rst_n", n_count, 0);
        check("rst_s", s_count, 0);
        check("rst_e", e_count, 0);
        check("rst_w", w_count, 0);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        n_rst = 1'b1;
        tick(2);

        // Arrival latency and held-high sensor
        arrive = 4'b1000;
        tick(2);
        check("n_before_edge3", n_count, 0);
        tick(1);
        check("n_after_edge3", n_count, 1);
        tick(21);
        check("n_held", n_count, 1);
        check("s_untouched", s_count, 0);
        arrive = 4'b0000;
        tick(3);

        // Saturation at 50 and sticky overflow on east
        for (int i = 0; i < 50; i++) pulse(4'b0010);
        check("e_50", e_count, 50);
        check("full_e", full, 4'b0010);
        check("ovf_none", ovf, 0);
        pulse(4'b0010);
        check("e_sat", e_count, 50);
        check("ovf_e", ovf, 4'b0010);
        depart = 4'b0010;
        tick(1);
        depart = 4'b0000;
        check("e_49", e_count, 49);
        check("ovf_e_sticky", ovf, 4'b0010);
        check("full_e_gone", full, 0);

        // Underflow on west, then clear
        depart = 4'b0001;
        tick(1);
        depart = 4'b0000;
        check("w_udf_cnt", w_count, 0);
        check("udf_w", udf, 4'b0001);
        do_clear();
        check("udf_clr", udf, 0);
        check("ovf_clr", ovf, 0);
        check("n_clr", n_count, 0);
        check("e_clr", e_count, 0);

        // Coincident arrival event and departure on south at 0
        arrive = 4'b0100;
        tick(2);
        depart = 4'b0100;
        tick(1);
        depart = 4'b0000;
        check("s_coinc0", s_count, 0);
        check("udf_coinc0", udf, 0);
        arrive = 4'b0000;
        tick(3);
        check("s_coinc0_after", s_count, 0);

        // Same at 50
        for (int i = 0; i < 50; i++) pulse(4'b0100);
        check("s_50", s_count, 50);
        arrive = 4'b0100;
        tick(2);
        depart = 4'b0100;
        tick(1);
        depart = 4'b0000;
        check("s_coinc50", s_count, 50);
        check("ovf_coinc50", ovf, 0);
        check("udf_coinc50", udf, 0);
        check("full_s", full, 4'b0100);
        arrive = 4'b0000;
        tick(3);

        // Independent directions: N=10 S=5 E=3 W=7, then depart all four
        do_clear();
        for (int i = 0; i < 10; i++) pulse({i < 10, i < 5, i < 3, i < 7});
        check("mix_n", n_count, 10);
        check("mix_s", s_count, 5);
        check("mix_e", e_count, 3);
        check("mix_w", w_count, 7);
        depart = 4'b1111;
        tick(1);
        depart = 4'b0000;
        check("dep_n", n_count, 9);
        check("dep_s", s_count, 4);
        check("dep_e", e_count, 2);
        check("dep_w", w_count, 6);
        do_clear();
        check("clr_n", n_count, 0);
        check("clr_s", s_count, 0);
        check("clr_e", e_count, 0);
        check("clr_w", w_count, 0);

        // Asynchronous reset mid-burst, south held high through release
        pulse(4'b1111);
        pulse(4'b1111);
        check("pre_rst_n", n_count, 2);
        arrive = 4'b1111;
        tick(1);
        #2 n_rst = 1'b0;
        #1;
        check("arst_n", n_count, 0);
        check("arst_s", s_count, 0);
        check("arst_e", e_count, 0);
        check("arst_w", w_count, 0);
        check("arst_full", full, 0);
        arrive = 4'b0100;
        tick(2);
        n_rst = 1'b1;
        tick(2);
        check("rel_s_early", s_count, 0);
        tick(1);
        check("rel_s", s_count, 1);
        tick(5);
        check("rel_s_hold", s_count, 1);
        check("rel_n", n_count, 0);
        arrive = 4'b0000;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/car_counter.md
# car_counter

Per-direction vehicle occupancy counter for the intersection controller. Sits directly upstream of the car-score stage: it turns raw N/S/E/W loop-sensor levels and light-controller departure pulses into four saturating queue counts (0..50), which the score stage sums into NS/EW totals. It also reports saturation and sticky overflow/underflow flags for diagnostics.

## Interface

- MAX_COUNT, 50, saturation ceiling per direction; legal range 1..63.
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear of all counts and flags.
- arrive  input  4  raw loop-sensor levels, bit 3 = N, 2 = S, 1 = E, 0 = W; asynchronous to clk.
- depart  input  4  departure pulses from the light controller, same bit order; synchronous to clk, one pulse per departing car.
- n_count  output  6  cars queued northbound.
- s_count  output  6  cars queued southbound.
- e_count  output  6  cars queued eastbound.
- w_count  output  6  cars queued westbound.
- full  output  4  count == MAX_COUNT, per direction.
- ovf  output  4  sticky: an arrival was dropped at MAX_COUNT.
- udf  output  4  sticky: a departure was seen at count 0.

## Operation

- Each arrive bit passes through a 2-flop synchronizer, then a history flop. An arrival event is sync2 = 1 and hist = 0, i.e. a rising edge. A held-high sensor counts once.
- depart bits are used directly. Each cycle the bit is high counts as one departure.
- Per-direction update, in priority order:
  - clear: count = 0, ovf = 0, udf = 0.
  - Arrival and departure in the same cycle: count unchanged at any value, including 0 and MAX. No flag is set.
  - Arrival only: if count < MAX_COUNT, count + 1. Otherwise hold and set ovf.
  - Departure only: if count > 0, count - 1. Otherwise hold and set udf.
- Count arithmetic is 6-bit unsigned. Counts never wrap and never exceed MAX_COUNT.
- full is combinational from the registered count.
- clear does not affect the synchronizer or history flops. An edge detected during the clear cycle is discarded.
- The four directions are fully independent. Events in different directions in the same cycle all take effect.

## Timing

- Reset values: all counts 0, full = 0, ovf = 0, udf = 0. Synchronizer and history flops reset to 0.
- A sensor already high when reset is released produces one arrival. That car is counted.
- Arrival latency: arrive rising before clk edge 1 (setup met) is captured into sync1 at edge 1 and sync2 at edge 2. The count increments at edge 3 and is visible after edge 3.
- Departure latency: depart high before edge k decrements the count at edge k.
- Minimum sensor high and low time is 2 clk cycles each for guaranteed detection. Shorter glitches may be missed.
- Asserting n_rst mid-operation immediately zeroes all state. There is no recovery of counts.
- All outputs are registered or derived from registers, so the score stage sees stable values for a full cycle.

## Structure

- Shared package car_pkg:
  - CAR_W = 6.
  - MAX_CARS = 50.
  - Direction index constants DIR_N = 3, DIR_S = 2, DIR_E = 1, DIR_W = 0, shared with the score stage and the light controller.
- Sub-module dir_counter, instantiated 4 times. It holds one direction's synchronizer, edge detector, saturating counter, and ovf/udf flags. Its ports are clk, n_rst, clear, arrive, depart, count, full, ovf, udf, and it takes MAX_COUNT as a parameter.
- Top level: instantiation only, plus bit-to-port mapping.

## Test plan

- Reset, then a 4-cycle high pulse on arrive[3]: n_count = 1 after edge 3 post-rise, other counts 0. Holding arrive[3] high for 20 more cycles leaves n_count = 1.
- 50 separated pulses on arrive[1]: e_count = 50 and full[1] = 1. A 51st pulse leaves e_count = 50 and sets ovf[1] = 1. ovf[1] stays set after a later depart[1].
- Pulse depart[0] with w_count = 0: w_count stays 0 and udf[0] = 1. A following clear returns udf[0] = 0.
- Same-cycle arrival event and depart[2] with s_count = 0, then again with s_count = 50: s_count unchanged both times and no flags set.
- Counts N = 10, S = 5, E = 3, W = 7, then depart on all four bits in one cycle: counts 9/4/2/6. Then clear: all 0.
- n_rst asserted mid-burst with counts nonzero: all outputs 0 immediately, asynchronously. arrive[2] held high through reset release yields s_count = 1.
